// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the instruction-fetch (IF) and the
// load/store (LS) requesters of the CPU core. Each access runs IDLE -> ISSUE ->
// WAIT -> IDLE. A one-cycle rsp_valid pulse goes to the granted requester in the
// first IDLE cycle after the access.
//
// Ports
//   clk, s_reset                 clock, synchronous active-high reset
//   if_req_* / if_addr           IF read request (valid/ready)
//   if_rsp_valid / if_rdata      IF read response (one-cycle pulse, data held)
//   ls_req_* / ls_addr / ls_we / ls_be / ls_wdata   LS read/write request
//   ls_rsp_valid / ls_rdata      LS response (read data or write ack)
//   mem_en/we/be/addr/wdata      RAM command, valid in the ISSUE cycle
//   mem_rdata                    RAM read data, MEM_LATENCY cycles after mem_en
//   busy                         high whenever the FSM is not in IDLE
module mem_port_arbiter #(
  parameter int CPU_WIDTH   = 32,
  parameter int RAM_WIDTH   = 31,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   s_reset,
  input  logic                   if_req_valid,
  output logic                   if_req_ready,
  input  logic [RAM_WIDTH-1:0]   if_addr,
  output logic                   if_rsp_valid,
  output logic [CPU_WIDTH-1:0]   if_rdata,
  input  logic                   ls_req_valid,
  output logic                   ls_req_ready,
  input  logic [RAM_WIDTH-1:0]   ls_addr,
  input  logic                   ls_we,
  input  logic [CPU_WIDTH/8-1:0] ls_be,
  input  logic [CPU_WIDTH-1:0]   ls_wdata,
  output logic                   ls_rsp_valid,
  output logic [CPU_WIDTH-1:0]   ls_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [CPU_WIDTH/8-1:0] mem_be,
  output logic [RAM_WIDTH-1:0]   mem_addr,
  output logic [CPU_WIDTH-1:0]   mem_wdata,
  input  logic [CPU_WIDTH-1:0]   mem_rdata,
  output logic                   busy
);

  localparam int BE_W = CPU_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  state_t                 state_r;
  state_t                 state_s;
  logic                   last_grant_r;
  logic                   grant_r;
  logic                   win_s;
  logic                   if_ready_s;
  logic                   ls_ready_s;
  logic                   accept_s;
  logic                   last_wait_s;
  logic                   we_next_s;
  logic [BE_W-1:0]        be_next_s;
  logic                   we_r;
  logic [BE_W-1:0]        be_r;
  logic [RAM_WIDTH-1:0]   addr_r;
  logic [CPU_WIDTH-1:0]   wdata_r;
  logic [3:0]             cnt_r;
  logic                   mem_en_r;
  logic                   mem_we_r;
  logic [BE_W-1:0]        mem_be_r;
  logic                   if_rsp_r;
  logic                   ls_rsp_r;
  logic [CPU_WIDTH-1:0]   if_rdata_r;
  logic [CPU_WIDTH-1:0]   ls_rdata_r;
  logic                   busy_r;

  // Round-robin winner selection and the combinational ready handshake.
  always_comb begin
    win_s      = GRANT_IF;
    if_ready_s = 1'b0;
    ls_ready_s = 1'b0;
    if (if_req_valid && ls_req_valid) begin
      // On a tie the port that did not win last time goes first.
      if (last_grant_r == GRANT_LS) begin
        win_s = GRANT_IF;
      end else begin
        win_s = GRANT_LS;
      end
    end else if (ls_req_valid) begin
      win_s = GRANT_LS;
    end else begin
      win_s = GRANT_IF;
    end
    if ((state_r == IDLE) && !s_reset) begin
      if_ready_s = if_req_valid && (win_s == GRANT_IF);
      ls_ready_s = ls_req_valid && (win_s == GRANT_LS);
    end else begin
      if_ready_s = 1'b0;
      ls_ready_s = 1'b0;
    end
  end

  // Command fields captured on accept; IF and LS reads always use full byte enables.
  always_comb begin
    we_next_s = 1'b0;
    be_next_s = {BE_W{1'b1}};
    if ((win_s == GRANT_LS) && ls_we) begin
      we_next_s = 1'b1;
      be_next_s = ls_be;
    end else begin
      we_next_s = 1'b0;
      be_next_s = {BE_W{1'b1}};
    end
  end

  assign accept_s    = if_ready_s || ls_ready_s;
  assign last_wait_s = (state_r == WAIT) && (cnt_r == 4'd1);

  // Next-state logic for the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, RAM command, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      last_grant_r <= GRANT_LS;
      grant_r      <= GRANT_IF;
      we_r         <= 1'b0;
      be_r         <= {BE_W{1'b0}};
      addr_r       <= {RAM_WIDTH{1'b0}};
      wdata_r      <= {CPU_WIDTH{1'b0}};
      cnt_r        <= 4'd0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= {BE_W{1'b0}};
      if_rsp_r     <= 1'b0;
      ls_rsp_r     <= 1'b0;
      if_rdata_r   <= {CPU_WIDTH{1'b0}};
      ls_rdata_r   <= {CPU_WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        last_grant_r <= win_s;
        grant_r      <= win_s;
        we_r         <= we_next_s;
        be_r         <= be_next_s;
        if (win_s == GRANT_LS) begin
          addr_r  <= ls_addr;
          wdata_r <= ls_wdata;
        end else begin
          addr_r  <= if_addr;
        end
      end
      // The strobes are registered from the accept so they are high exactly in ISSUE.
      mem_en_r <= accept_s;
      mem_we_r <= accept_s && we_next_s;
      mem_be_r <= accept_s ? be_next_s : {BE_W{1'b0}};
      case (state_r)
        ISSUE:   cnt_r <= 4'(MEM_LATENCY);
        WAIT:    cnt_r <= cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase
      if_rsp_r <= last_wait_s && (grant_r == GRANT_IF);
      ls_rsp_r <= last_wait_s && (grant_r == GRANT_LS);
      if (last_wait_s && (grant_r == GRANT_IF)) begin
        if_rdata_r <= mem_rdata;
      end
      // Writes are acknowledged only; ls_rdata keeps the last read value.
      if (last_wait_s && (grant_r == GRANT_LS) && !we_r) begin
        ls_rdata_r <= mem_rdata;
      end
      busy_r <= (state_s != IDLE);
    end
  end

  assign if_req_ready = if_ready_s;
  assign ls_req_ready = ls_ready_s;
  assign if_rsp_valid = if_rsp_r;
  assign if_rdata     = if_rdata_r;
  assign ls_rsp_valid = ls_rsp_r;
  assign ls_rdata     = ls_rdata_r;
  assign mem_en       = mem_en_r;
  assign mem_we       = mem_we_r;
  assign mem_be       = mem_be_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LATENCY=1 (index 0) and one
// with MEM_LATENCY=3 (index 1), each attached to a small behavioural RAM.
// Expected RAM commands and responses are queued when a request is accepted
// and checked when the DUT produces them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_reset;
  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [30:0] if_addr      [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rdata     [2];
  logic        ls_req_valid [2];
  logic        ls_req_ready [2];
  logic [30:0] ls_addr      [2];
  logic        ls_we        [2];
  logic [3:0]  ls_be        [2];
  logic [31:0] ls_wdata     [2];
  logic        ls_rsp_valid [2];
  logic [31:0] ls_rdata     [2];
  logic        mem_en       [2];
  logic        mem_we       [2];
  logic [3:0]  mem_be       [2];
  logic [30:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic [31:0] mem_rdata    [2];
  logic        busy         [2];

  mem_port_arbiter #(.CPU_WIDTH(32), .RAM_WIDTH(31), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .s_reset(s_reset),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_addr(if_addr[0]),
    .if_rsp_valid(if_rsp_valid[0]), .if_rdata(if_rdata[0]),
    .ls_req_valid(ls_req_valid[0]), .ls_req_ready(ls_req_ready[0]), .ls_addr(ls_addr[0]),
    .ls_we(ls_we[0]), .ls_be(ls_be[0]), .ls_wdata(ls_wdata[0]),
    .ls_rsp_valid(ls_rsp_valid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.CPU_WIDTH(32), .RAM_WIDTH(31), .MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .s_reset(s_reset),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_addr(if_addr[1]),
    .if_rsp_valid(if_rsp_valid[1]), .if_rdata(if_rdata[1]),
    .ls_req_valid(ls_req_valid[1]), .ls_req_ready(ls_req_ready[1]), .ls_addr(ls_addr[1]),
    .ls_we(ls_we[1]), .ls_be(ls_be[1]), .ls_wdata(ls_wdata[1]),
    .ls_rsp_valid(ls_rsp_valid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  typedef struct packed {
    logic        inst;
    logic [31:0] due;
    logic        we;
    logic [3:0]  be;
    logic [30:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_if  [$];
  exp_t exp_ls  [$];
  exp_t exp_mem [$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        mon_en = 1'b0;
  logic        ram_init = 1'b0;
  int          act_acc [2];
  int          act_due [2];
  logic [31:0] last_ls [2];
  logic [31:0] ref_mem [2][256];
  logic [31:0] ram     [2][256];
  logic [31:0] pipe    [2][4];
  exp_t        me;
  int          a1, a2, a3, a4;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 16) return 32'hDEADBEEF;
    return {b, ~b, b, 8'hA5};
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Behavioural RAM: byte-enabled writes, reads delayed through a shift pipe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (ram_init) begin
        for (int i = 0; i < 256; i++) ram[k][i] <= pat(i);
      end else if (mem_en[k] && mem_we[k]) begin
        ram[k][mem_addr[k][7:0]] <= merge_be(ram[k][mem_addr[k][7:0]], mem_wdata[k], mem_be[k]);
      end
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? ram[k][mem_addr[k][7:0]] : 32'hBAADF00D;
      for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Output monitor: RAM commands, responses, busy and ready exclusivity.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (mem_en[k]) begin
          if (exp_mem.size() == 0) begin
            check_val("mem_en_unexpected", 64'd1, 64'd0);
          end else begin
            me = exp_mem.pop_front();
            check_val("mem_inst", 64'(k), 64'(me.inst));
            check_val("mem_cycle", 64'(cyc), 64'(me.due));
            check_val("mem_addr", 64'(mem_addr[k]), 64'(me.addr));
            check_val("mem_we", 64'(mem_we[k]), 64'(me.we));
            check_val("mem_be", 64'(mem_be[k]), 64'(me.be));
            if (me.we) check_val("mem_wdata", 64'(mem_wdata[k]), 64'(me.data));
          end
        end else begin
          check_val("mem_idle_we_be", 64'({mem_we[k], mem_be[k]}), 64'd0);
        end
        if (if_rsp_valid[k]) begin
          if (exp_if.size() == 0) begin
            check_val("if_rsp_unexpected", 64'd1, 64'd0);
          end else begin
            me = exp_if.pop_front();
            check_val("if_rsp_inst", 64'(k), 64'(me.inst));
            check_val("if_rsp_cycle", 64'(cyc), 64'(me.due));
            check_val("if_rdata", 64'(if_rdata[k]), 64'(me.data));
          end
        end
        if (ls_rsp_valid[k]) begin
          if (exp_ls.size() == 0) begin
            check_val("ls_rsp_unexpected", 64'd1, 64'd0);
          end else begin
            me = exp_ls.pop_front();
            check_val("ls_rsp_inst", 64'(k), 64'(me.inst));
            check_val("ls_rsp_cycle", 64'(cyc), 64'(me.due));
            check_val(me.we ? "ls_rdata_after_write" : "ls_rdata", 64'(ls_rdata[k]), 64'(me.data));
          end
        end
        check_val("busy", 64'(busy[k]), 64'((cyc > act_acc[k]) && (cyc < act_due[k])));
        check_val("ready_exclusive", 64'(if_req_ready[k] && ls_req_ready[k]), 64'd0);
      end
    end
  end

  task automatic if_rd(input int k, input logic [30:0] a, output int acc);
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    if_req_valid[k] = 1'b1;
    if_addr[k]      = a;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (if_req_ready[k]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check_val("if_accept_timeout", 64'd0, 64'd1);
      if_req_valid[k] = 1'b0;
    end else begin
      acc = cyc;
      act_acc[k] = cyc;
      act_due[k] = cyc + lat(k) + 2;
      e.inst = 1'(k); e.we = 1'b0; e.be = 4'hF; e.addr = a;
      e.due  = 32'(cyc + lat(k) + 2);
      e.data = ref_mem[k][a[7:0]];
      exp_if.push_back(e);
      e.due  = 32'(cyc + 1);
      e.data = 32'd0;
      exp_mem.push_back(e);
      @(posedge clk);
      #1;
      if_req_valid[k] = 1'b0;
    end
  endtask

  task automatic ls_op(input int k, input logic we, input logic [30:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output int acc);
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    ls_req_valid[k] = 1'b1;
    ls_addr[k]      = a;
    ls_we[k]        = we;
    ls_be[k]        = be;
    ls_wdata[k]     = wd;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (ls_req_ready[k]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check_val("ls_accept_timeout", 64'd0, 64'd1);
      ls_req_valid[k] = 1'b0;
    end else begin
      acc = cyc;
      act_acc[k] = cyc;
      act_due[k] = cyc + lat(k) + 2;
      e.inst = 1'(k); e.we = we; e.addr = a;
      e.be   = we ? be : 4'hF;
      if (we) begin
        ref_mem[k][a[7:0]] = merge_be(ref_mem[k][a[7:0]], wd, be);
        e.data = last_ls[k];
      end else begin
        e.data = ref_mem[k][a[7:0]];
        last_ls[k] = e.data;
      end
      e.due = 32'(cyc + lat(k) + 2);
      exp_ls.push_back(e);
      e.due  = 32'(cyc + 1);
      e.data = wd;
      exp_mem.push_back(e);
      @(posedge clk);
      #1;
      ls_req_valid[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    s_reset = 1'b1;
    ram_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req_valid[k] = 1'b0; if_addr[k] = 31'd0;
      ls_req_valid[k] = 1'b0; ls_addr[k] = 31'd0; ls_we[k] = 1'b0;
      ls_be[k] = 4'd0; ls_wdata[k] = 32'd0;
      act_acc[k] = 0; act_due[k] = 0; last_ls[k] = 32'd0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = pat(i);
    end

    // Reset values after two reset cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val("rst_rsp_valid", 64'({if_rsp_valid[k], ls_rsp_valid[k]}), 64'd0);
      check_val("rst_if_rdata", 64'(if_rdata[k]), 64'd0);
      check_val("rst_ls_rdata", 64'(ls_rdata[k]), 64'd0);
      check_val("rst_mem_ctrl", 64'({mem_en[k], mem_we[k], mem_be[k]}), 64'd0);
      check_val("rst_mem_addr", 64'(mem_addr[k]), 64'd0);
      check_val("rst_mem_wdata", 64'(mem_wdata[k]), 64'd0);
      check_val("rst_busy", 64'(busy[k]), 64'd0);
      if_req_valid[k] = 1'b1;
      ls_req_valid[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_ready_low", 64'({if_req_ready[k], ls_req_ready[k]}), 64'd0);
      if_req_valid[k] = 1'b0;
      ls_req_valid[k] = 1'b0;
    end
    @(negedge clk);
    s_reset  = 1'b0;
    ram_init = 1'b0;
    mon_en   = 1'b1;

    // First tie from reset: IF (0x10) first, LS in IF's response cycle.
    fork
      if_rd(0, 31'h10, a1);
      ls_op(0, 1'b0, 31'h11, 4'h0, 32'd0, a2);
    join
    check_val("tie1_if_first", 64'(a1 < a2), 64'd1);
    check_val("tie1_ls_gap", 64'(a2 - a1), 64'd3);

    // IF alone, then both keep requesting: LS, IF, LS, IF.
    if_rd(0, 31'h12, a1);
    fork
      begin ls_op(0, 1'b0, 31'h13, 4'h5, 32'd0, a1); ls_op(0, 1'b0, 31'h14, 4'h0, 32'd0, a3); end
      begin if_rd(0, 31'h15, a2); if_rd(0, 31'h16, a4); end
    join
    check_val("tie2_order_ls_if", 64'(a2 - a1), 64'd3);
    check_val("tie2_order_if_ls", 64'(a3 - a2), 64'd3);
    check_val("tie2_order_ls_if2", 64'(a4 - a3), 64'd3);

    // Partial write, read back, zero-byte-enable write, read back.
    ls_op(0, 1'b1, 31'h20, 4'b0011, 32'h12345678, a1);
    ls_op(0, 1'b0, 31'h20, 4'h0, 32'd0, a1);
    ls_op(0, 1'b1, 31'h21, 4'b0000, 32'hCAFEF00D, a1);
    ls_op(0, 1'b0, 31'h21, 4'hF, 32'd0, a1);
    check_val("write_readback_ref", 64'(ref_mem[0][8'h20]), 64'h20DF5678);

    // Latency 3: LS read, then back-to-back IF reads every 5 cycles.
    ls_op(1, 1'b0, 31'h7, 4'h0, 32'd0, a1);
    if_rd(1, 31'h30, a1);
    if_rd(1, 31'h31, a2);
    check_val("l3_if_b2b_gap", 64'(a2 - a1), 64'd5);
    ls_op(1, 1'b1, 31'h32, 4'b1100, 32'hA1B2C3D4, a1);

    // Reset in the first WAIT cycle of an LS read: the access is dropped.
    ls_op(1, 1'b0, 31'h40, 4'h0, 32'd0, a1);
    @(negedge clk);
    @(negedge clk);
    #1;
    s_reset = 1'b1;
    exp_if.delete();
    exp_ls.delete();
    exp_mem.delete();
    for (int k = 0; k < 2; k++) begin
      act_acc[k] = 0; act_due[k] = 0; last_ls[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check_val("midrst_busy", 64'(busy[1]), 64'd0);
    check_val("midrst_mem_en", 64'(mem_en[1]), 64'd0);
    s_reset = 1'b0;
    repeat (4) @(negedge clk);

    // First tie after reset again goes to IF.
    fork
      if_rd(1, 31'h50, a1);
      ls_op(1, 1'b0, 31'h51, 4'h0, 32'd0, a2);
    join
    check_val("tie_post_rst_if_first", 64'(a1 < a2), 64'd1);
    check_val("tie_post_rst_gap", 64'(a2 - a1), 64'd5);

    repeat (10) @(negedge clk);
    check_val("queues_drained", 64'(exp_if.size() + exp_ls.size() + exp_mem.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port RAM between two requesters: instruction fetch (IF) and data load/store (LS).
- Round-robin arbitration with valid/ready request handshakes and a one-cycle response pulse per requester.
- Sequences each RAM access through issue and latency-wait states.
- Sits between the cpu core pipeline and its RAM instance.

Parameters:
- CPU_WIDTH, 32, data width; must be a multiple of 8.
- RAM_WIDTH, 31, word-address width.
- MEM_LATENCY, 1, RAM read latency in cycles; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on posedge.
- s_reset  in  1  reset, synchronous, active-high.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  RAM_WIDTH  IF address.
- if_rsp_valid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  CPU_WIDTH  IF read data.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_addr  in  RAM_WIDTH  LS address.
- ls_we  in  1  1 = write, 0 = read.
- ls_be  in  CPU_WIDTH/8  write byte enables.
- ls_wdata  in  CPU_WIDTH  write data.
- ls_rsp_valid  out  1  one-cycle pulse: read data valid, or write acknowledge.
- ls_rdata  out  CPU_WIDTH  LS read data.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_be  out  CPU_WIDTH/8  RAM byte enables.
- mem_addr  out  RAM_WIDTH  RAM address.
- mem_wdata  out  CPU_WIDTH  RAM write data.
- mem_rdata  in  CPU_WIDTH  RAM read data, valid MEM_LATENCY cycles after the mem_en cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- **State machine:** states IDLE, ISSUE, WAIT.
- **Ready signals:** if_req_ready and ls_req_ready are combinational. Only the arbitration winner sees ready=1, and only in IDLE. Both are 0 in ISSUE and WAIT.
- **Arbitration (IDLE):**
  - One port valid: that port wins.
  - Both valid: the port not in last_grant wins.
  - last_grant updates on every accept.
- **Accept (cycle T):** on valid&ready, register addr, we, be and wdata, plus the grant id; go to ISSUE.
  - IF requests register we=0 and be=all ones.
  - LS reads register be=all ones; ls_be is ignored.
- **ISSUE (cycle T+1):** mem_en=1 for exactly this cycle. mem_we, mem_be, mem_addr and mem_wdata are driven from the registers. Load the wait counter with MEM_LATENCY; go to WAIT.
- **WAIT (cycles T+2 .. T+1+MEM_LATENCY):** the counter decrements each cycle.
  - In the last WAIT cycle (cycle T+1+MEM_LATENCY), sample mem_rdata into the granted port's rdata register.
  - Then set that port's rsp_valid and go to IDLE.
- **Response timing:**
  - rsp_valid is high for exactly one cycle, at T+2+MEM_LATENCY; this is also the first IDLE cycle.
  - A new request may be accepted in that same cycle.
  - Throughput is one access per MEM_LATENCY+2 cycles.
- **Writes:** ls_rsp_valid pulses as the acknowledge; ls_rdata is not updated on writes.
- **Output holding:**
  - rdata outputs hold their value until the next read response to the same port.
  - Outside ISSUE: mem_en=0, mem_we=0, mem_be=0; mem_addr and mem_wdata hold their last values.
- **Protocol rules:**
  - Requesters hold request fields stable until accepted.
  - Dropping valid before ready has no effect.
  - A write with ls_be=0 still performs a RAM cycle with mem_be=0 and is acknowledged.
- **Reset:**
  - On a clk edge with s_reset=1: state=IDLE; all outputs and registers are 0; last_grant=LS, so the first tie goes to IF.
  - Reset mid-operation (ISSUE or WAIT) discards the in-flight access: no rsp_valid, and mem_en=0 from the next cycle.
  - The requester must re-issue after reset.
  - While s_reset=1, both ready signals are 0.

Test Plan:
- **Reset values:** hold s_reset for 2 cycles -> all outputs 0, busy=0. Release; IF read addr 0x10 with mem_rdata=0xDEADBEEF -> if_req_ready at T, mem_en only at T+1 with mem_addr=0x10, if_rsp_valid=1 and if_rdata=0xDEADBEEF at T+3 (MEM_LATENCY=1), busy=1 for T+1..T+2.
- **Tie arbitration:** IF and LS valid together from reset -> IF granted first, then LS in the first IDLE cycle after IF's response. A second tie is granted LS first, alternating thereafter; the loser is never starved.
- **LS write:** ls_we=1, addr 0x20, be=4'b0011, wdata=0x12345678 -> ISSUE cycle shows mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678. ls_rsp_valid pulses; ls_rdata is unchanged.
- **Latency sweep:** MEM_LATENCY=3, LS read addr 0x7 -> ls_rsp_valid at T+5. Back-to-back IF reads are accepted every 5 cycles.
- **Reset mid-operation:** assert s_reset during WAIT -> no rsp_valid, mem_en=0, state IDLE. The first post-reset tie is granted to IF.
- **Zero byte-enable write:** LS write with be=0 -> one mem_en cycle with mem_be=0; ls_rsp_valid still pulses.
